// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window scheduler slice.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned CALC_LAT = 4;

  // Number of full 3x3 windows produced from one w x h frame.
  function automatic int unsigned win_count(input int unsigned w, input int unsigned h);
    return (w - 2) * (h - 2);
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One-line pixel store: combinational read, synchronous write, contents never reset.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [PIX_W-1:0] i_wdata,
  output logic [PIX_W-1:0] o_rdata
);

  logic [PIX_W-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/sobel_window_sched.sv
// Raster-to-3x3-window scheduler feeding sobel_calc_mod; counts returned results
// so a frame completes only after the calc pipeline has drained.
module sobel_window_sched
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned CNT_W = $clog2(IMG_W * IMG_H) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [PIX_W-1:0] pix_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  output logic [PIX_W-1:0] d0_o,
  output logic [PIX_W-1:0] d1_o,
  output logic [PIX_W-1:0] d2_o,
  output logic [PIX_W-1:0] d3_o,
  output logic [PIX_W-1:0] d4_o,
  output logic [PIX_W-1:0] d5_o,
  output logic [PIX_W-1:0] d6_o,
  output logic [PIX_W-1:0] d7_o,
  output logic [PIX_W-1:0] d8_o,
  output logic             win_valid_o,
  input  logic             calc_done_i,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic [CNT_W-1:0] out_cnt_o
);

  localparam int unsigned      CW    = $clog2(IMG_W);
  localparam int unsigned      RW    = $clog2(IMG_H);
  localparam logic [CNT_W-1:0] E_CNT = CNT_W'(win_count(IMG_W, IMG_H));

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [CNT_W-1:0] r_out_cnt;
  logic [CNT_W-1:0] w_out_cnt_nxt;
  logic [PIX_W-1:0] r_win [9];
  logic             r_win_valid;
  logic             w_accept;
  logic             w_start;
  logic             w_last_pix;
  logic             w_win_ok;
  logic             w_counting;
  logic [PIX_W-1:0] w_lb0_rd;
  logic [PIX_W-1:0] w_lb1_rd;

  assign w_accept   = pix_valid_i & pix_ready_o;
  assign w_start    = (r_state == ST_IDLE) & start_i;
  assign w_last_pix = w_accept & (r_row == RW'(IMG_H - 1)) & (r_col == CW'(IMG_W - 1));
  assign w_win_ok   = (r_row >= RW'(2)) & (r_col >= CW'(2));
  assign w_counting = (r_state == ST_RUN) | (r_state == ST_DRAIN);

  // Row-pair shift: lb1 keeps row r-1, lb0 receives what lb1 held (row r-2).
  sobel_line_buf #(
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_lb0 (
    .i_clk   (clk),
    .i_we    (w_accept),
    .i_addr  (r_col),
    .i_wdata (w_lb1_rd),
    .o_rdata (w_lb0_rd)
  );

  sobel_line_buf #(
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_lb1 (
    .i_clk   (clk),
    .i_we    (w_accept),
    .i_addr  (r_col),
    .i_wdata (pix_i),
    .o_rdata (w_lb1_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Drain exit looks at the next count so a result arriving this cycle is included.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start_i) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_last_pix) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_out_cnt_nxt == E_CNT) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_ready_o  = 1'b0;
    busy_o       = 1'b0;
    frame_done_o = 1'b0;
    unique case (r_state)
      ST_IDLE:  ;
      ST_RUN: begin
        pix_ready_o = 1'b1;
        busy_o      = 1'b1;
      end
      ST_DRAIN: busy_o = 1'b1;
      ST_DONE: begin
        busy_o       = 1'b1;
        frame_done_o = 1'b1;
      end
      default:  ;
    endcase
  end

  always_comb begin
    w_out_cnt_nxt = r_out_cnt;
    if (w_start) begin
      w_out_cnt_nxt = '0;
    end else if (w_counting && calc_done_i && (r_out_cnt != E_CNT)) begin
      w_out_cnt_nxt = r_out_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_cnt <= '0;
    end else begin
      r_out_cnt <= w_out_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == CW'(IMG_W - 1)) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 9; i++) begin
        r_win[i] <= '0;
      end
      r_win_valid <= 1'b0;
    end else begin
      r_win_valid <= w_accept & w_win_ok;
      if (w_accept) begin
        for (int unsigned k = 0; k < 3; k++) begin
          r_win[3*k]   <= r_win[3*k+1];
          r_win[3*k+1] <= r_win[3*k+2];
        end
        r_win[2] <= w_lb0_rd;
        r_win[5] <= w_lb1_rd;
        r_win[8] <= pix_i;
      end
    end
  end

  assign d0_o        = r_win[0];
  assign d1_o        = r_win[1];
  assign d2_o        = r_win[2];
  assign d3_o        = r_win[3];
  assign d4_o        = r_win[4];
  assign d5_o        = r_win[5];
  assign d6_o        = r_win[6];
  assign d7_o        = r_win[7];
  assign d8_o        = r_win[8];
  assign win_valid_o = r_win_valid;
  assign out_cnt_o   = r_out_cnt;

endmodule

// File: tb/tb_sobel_window_sched.sv
// Self-checking bench for sobel_window_sched on a 4x4 frame with a 4-cycle calc model.
module tb_sobel_window_sched;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int E    = (W - 2) * (H - 2);
  localparam int CNTW = $clog2(W * H) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic [7:0]      pix_i;
  logic            pix_valid_i;
  logic            pix_ready_o;
  logic [7:0]      d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
  logic            win_valid_o;
  logic            calc_done_i;
  logic            busy_o;
  logic            frame_done_o;
  logic [CNTW-1:0] out_cnt_o;
  logic [71:0]     w_dut;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          row;
    int          col;
    logic [71:0] d;
  } vec_t;
  vec_t tbl [4];

  always #5 clk = ~clk;

  sobel_window_sched #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .pix_i        (pix_i),
    .pix_valid_i  (pix_valid_i),
    .pix_ready_o  (pix_ready_o),
    .d0_o         (d0_o),
    .d1_o         (d1_o),
    .d2_o         (d2_o),
    .d3_o         (d3_o),
    .d4_o         (d4_o),
    .d5_o         (d5_o),
    .d6_o         (d6_o),
    .d7_o         (d7_o),
    .d8_o         (d8_o),
    .win_valid_o  (win_valid_o),
    .calc_done_i  (calc_done_i),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .out_cnt_o    (out_cnt_o)
  );

  assign w_dut = {d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o};

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_win_valid"}, 72'(win_valid_o), 72'd0);
    chk({tag, "_window"}, w_dut, 72'd0);
    chk({tag, "_ready"}, 72'(pix_ready_o), 72'd0);
    chk({tag, "_busy"}, 72'(busy_o), 72'd0);
    chk({tag, "_frame_done"}, 72'(frame_done_o), 72'd0);
    chk({tag, "_out_cnt"}, 72'(out_cnt_o), 72'd0);
  endtask

  // mode: 0 no results, 1 result 4 cycles after each window,
  //       2 result pulse every cycle from start, 3 pulses every cycle after last pixel.
  task automatic run_frame(input bit ramp, input bit randv, input int mode,
                           input bit noise, input int abort_at);
    logic [7:0]  img [NPIX];
    logic [71:0] expw [$];
    logic [71:0] w;
    int          pend [$];
    int          p = 0;
    int          m_cnt = 0;
    int          last_acc = -1;
    int          done_cyc = -1;
    int          seen_done = 0;
    int          act_done = -1;
    int          wins = 0;
    int          tbl_i = 0;
    int          prev_r = 0;
    int          prev_c = 0;
    bit          prev_acc = 1'b0;
    bit          finished = 1'b0;
    bit          v;
    bit          dc;

    for (int i = 0; i < NPIX; i++) img[i] = ramp ? 8'(i) : 8'($urandom);
    for (int r = 2; r < H; r++) begin
      for (int c = 2; c < W; c++) begin
        w = '0;
        for (int dr = 2; dr >= 0; dr--)
          for (int dcol = 2; dcol >= 0; dcol--)
            w = {w[63:0], img[(r - dr) * W + (c - dcol)]};
        expw.push_back(w);
      end
    end

    @(negedge clk);
    start_i     = 1'b1;
    pix_valid_i = 1'b0;
    calc_done_i = 1'b0;

    for (int n = 1; n < 150; n++) begin
      @(negedge clk);
      start_i = 1'b0;

      chk("win_valid", 72'(win_valid_o), 72'(prev_acc && prev_r >= 2 && prev_c >= 2));
      if (win_valid_o) begin
        wins++;
        if (expw.size() > 0) chk("window", w_dut, expw.pop_front());
        else chk("extra_window", 72'd1, 72'd0);
        if (ramp && tbl_i < 4) begin
          chk("tbl_window", w_dut, tbl[tbl_i].d);
          chk("tbl_pos", 72'(prev_r * W + prev_c), 72'(tbl[tbl_i].row * W + tbl[tbl_i].col));
          tbl_i++;
        end
        if (mode == 1) pend.push_back(n + 4);
      end
      chk("out_cnt", 72'(out_cnt_o), 72'(m_cnt));
      chk("pix_ready", 72'(pix_ready_o), 72'(last_acc < 0));
      chk("busy", 72'(busy_o), 72'(done_cyc < 0 || n <= done_cyc));
      chk("frame_done", 72'(frame_done_o), 72'(n == done_cyc));
      if (frame_done_o) begin
        seen_done++;
        act_done = n;
      end
      if (done_cyc >= 0 && n >= done_cyc + 3) begin
        finished = 1'b1;
        break;
      end
      if (abort_at >= 0 && p == abort_at) return;

      dc = 1'b0;
      if (pend.size() > 0 && pend[0] == n) begin
        void'(pend.pop_front());
        dc = 1'b1;
      end
      if (mode == 2) dc = 1'b1;
      if (mode == 3 && last_acc >= 0) dc = 1'b1;
      calc_done_i = dc;

      if (noise && (n == 5 || n == done_cyc)) start_i = 1'b1;

      v = (p < NPIX) && (!randv || $urandom_range(0, 1) == 1);
      pix_valid_i = v;
      pix_i       = v ? img[p] : 8'($urandom);
      prev_acc    = v;
      if (v) begin
        prev_r = p / W;
        prev_c = p % W;
        if (p == NPIX - 1) last_acc = n;
        p++;
      end

      if (dc && done_cyc < 0 && m_cnt < E) m_cnt++;
      if (done_cyc < 0 && last_acc >= 0 && n > last_acc && m_cnt == E) done_cyc = n + 1;
    end

    calc_done_i = 1'b0;
    pix_valid_i = 1'b0;
    start_i     = 1'b0;
    chk("frame_timeout", 72'(finished), 72'd1);
    chk("done_count", 72'(seen_done), 72'd1);
    chk("window_count", 72'(wins), 72'(E));
    chk("windows_left", 72'(expw.size()), 72'd0);
    chk("final_out_cnt", 72'(out_cnt_o), 72'(E));
    if (mode == 1) chk("done_latency", 72'(act_done - last_acc), 72'd6);
  endtask

  initial begin
    tbl[0] = '{2, 2, {8'd0, 8'd1, 8'd2,  8'd4, 8'd5,  8'd6,  8'd8,  8'd9,  8'd10}};
    tbl[1] = '{2, 3, {8'd1, 8'd2, 8'd3,  8'd5, 8'd6,  8'd7,  8'd9,  8'd10, 8'd11}};
    tbl[2] = '{3, 2, {8'd4, 8'd5, 8'd6,  8'd8, 8'd9,  8'd10, 8'd12, 8'd13, 8'd14}};
    tbl[3] = '{3, 3, {8'd5, 8'd6, 8'd7,  8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}};

    rst         = 1'b1;
    start_i     = 1'b0;
    pix_i       = '0;
    pix_valid_i = 1'b0;
    calc_done_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");

    // Ramp frame with calc model: windows, result count, done latency.
    run_frame(1'b1, 1'b0, 1, 1'b0, -1);

    // Result pulses while idle leave the count alone.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      calc_done_i = 1'b1;
      chk("idle_cnt_hold", 72'(out_cnt_o), 72'(E));
      chk("idle_busy", 72'(busy_o), 72'd0);
    end
    @(negedge clk);
    calc_done_i = 1'b0;
    chk("idle_cnt_after", 72'(out_cnt_o), 72'(E));

    // Gappy pixel stream, start pulses in RUN/DONE, saturation cases.
    run_frame(1'b1, 1'b1, 1, 1'b0, -1);
    run_frame(1'b1, 1'b0, 1, 1'b1, -1);
    run_frame(1'b1, 1'b0, 3, 1'b0, -1);
    run_frame(1'b0, 1'b1, 2, 1'b0, -1);

    // Reset mid row 2, then a clean ramp frame.
    run_frame(1'b1, 1'b0, 1, 1'b0, 9);
    rst         = 1'b1;
    pix_valid_i = 1'b0;
    calc_done_i = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");
    run_frame(1'b1, 1'b0, 1, 1'b0, -1);

    for (int f = 0; f < 4; f++) run_frame(1'b0, 1'b1, 1, f[0], -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
